// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered round-robin multiplexer.
// Imported by rr_arbiter and rr_mux_reg.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // A two-input mux still needs one select bit, so the width never drops below 1.
    function automatic int calcSelWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request found after ptr_i,
// wrapping modulo N. The pointer register lives in the parent.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = calcSelWidth(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [SW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [SW-1:0] grantIdx_o,
    output logic          grantAny_o
);

    always_comb begin : searchBlk
        int cand;
        grant_o    = '0;
        grantIdx_o = '0;
        grantAny_o = 1'b0;
        cand       = 0;
        // Offset 1..N so the channel at ptr_i itself is searched last.
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr_i) + k) % N;
            if (!grantAny_o && req_i[cand]) begin
                grantAny_o    = 1'b1;
                grantIdx_o    = SW'(cand);
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_reg.sv
// N-input registered multiplexer with valid/ready handshakes, selectable between
// a fixed Select channel and fair round-robin arbitration.
module rr_mux_reg
    import mux_pkg::*;
#(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int SW = calcSelWidth(N)
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic [N*W-1:0] InData,
    input  logic [N-1:0]   InValid,
    output logic [N-1:0]   InReady,
    input  logic           Mode,
    input  logic [SW-1:0]  Select,
    output logic [W-1:0]   OutData,
    output logic [SW-1:0]  OutChan,
    output logic           OutValid,
    input  logic           OutReady
);

    logic [W-1:0]  outData_q,  outData_d;
    logic [SW-1:0] outChan_q,  outChan_d;
    logic          outValid_q, outValid_d;
    logic [SW-1:0] ptr_q,      ptr_d;

    logic          loadEn;
    logic [N-1:0]  arbOh;
    logic [SW-1:0] arbIdx;
    logic          arbAny;
    logic [N-1:0]  fixOh;
    logic          fixAny;
    logic [N-1:0]  gntOh;
    logic [SW-1:0] gntIdx;
    logic          gntAny;
    logic [W-1:0]  selData;
    logic          xfer;

    rr_arbiter #(
        .N  (N),
        .SW (SW)
    ) u_arbiter (
        .req_i      (InValid),
        .ptr_i      (ptr_q),
        .grant_o    (arbOh),
        .grantIdx_o (arbIdx),
        .grantAny_o (arbAny)
    );

    assign loadEn = !outValid_q || OutReady;

    // Out-of-range Select values never match any loop index, so they grant nothing.
    always_comb begin
        fixOh  = '0;
        fixAny = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (Select == SW'(i) && InValid[i]) begin
                fixOh[i] = 1'b1;
                fixAny   = 1'b1;
            end
        end
    end

    always_comb begin
        gntOh  = (Mode == MODE_RR) ? arbOh  : fixOh;
        gntIdx = (Mode == MODE_RR) ? arbIdx : Select;
        gntAny = (Mode == MODE_RR) ? arbAny : fixAny;
    end

    always_comb begin
        selData = '0;
        for (int i = 0; i < N; i++) begin
            if (gntIdx == SW'(i)) begin
                selData = InData[i*W +: W];
            end
        end
    end

    assign InReady = gntOh & {N{loadEn && RST_N}};
    assign xfer    = gntAny && loadEn;

    // A drain with no new grant clears valid but keeps the last data and channel.
    always_comb begin
        outData_d  = outData_q;
        outChan_d  = outChan_q;
        outValid_d = outValid_q;
        ptr_d      = ptr_q;
        if (xfer) begin
            outData_d  = selData;
            outChan_d  = gntIdx;
            outValid_d = 1'b1;
            if (Mode == MODE_RR) begin
                ptr_d = gntIdx;
            end
        end else if (OutReady) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            outData_q  <= '0;
            outChan_q  <= '0;
            outValid_q <= 1'b0;
            ptr_q      <= SW'(N-1);
        end else begin
            outData_q  <= outData_d;
            outChan_q  <= outChan_d;
            outValid_q <= outValid_d;
            ptr_q      <= ptr_d;
        end
    end

    assign OutData  = outData_q;
    assign OutChan  = outChan_q;
    assign OutValid = outValid_q;

endmodule

// File: doc/rr_mux_reg.md
Name: rr_mux_reg

Overview:
- Parametrised N-input, W-bit registered multiplexer with a valid/ready handshake on every input and on the output.
- Successor to the fixed 4x1 combinational mux used in the datapath.
- Two modes:
  - Mode 0 (fixed): the channel is chosen by a Select input, as before.
  - Mode 1 (round-robin): the block arbitrates fairly among valid inputs.
- Sits between multiple producers (register file, immediate, memory data, PC sources) and a single consumer stage of the multicycle datapath.

Parameters:
- W, 8, data width of each input and of the output.
- N, 4, number of input channels (2..16; non-power-of-two allowed).
- SW, $clog2(N), width of Select, OutChan and the internal pointer.

Ports:
- CLK, input, 1, rising-edge clock.
- RST_N, input, 1, synchronous active-low reset.
- InData, input, N*W, flattened channel data; channel i occupies bits [i*W+W-1 : i*W].
- InValid, input, N, per-channel valid.
- InReady, output, N, per-channel ready (combinational).
- Mode, input, 1, 0 = fixed Select, 1 = round-robin.
- Select, input, SW, channel index used in Mode 0.
- OutData, output, W, registered selected data.
- OutChan, output, SW, index of the channel that produced OutData.
- OutValid, output, 1, OutData/OutChan hold an unconsumed word.
- OutReady, input, 1, consumer accepts the word this cycle.

Behaviour:
- Reset: all actions happen on a CLK edge with RST_N=0.
  - Outputs: OutValid=0, OutData=0, OutChan=0.
  - Internal pointer Ptr=N-1, so the first round-robin search starts at channel 0.
  - Reset mid-transfer discards the held word. No InReady is asserted while RST_N=0.
- Load enable: LoadEn = !OutValid || OutReady. This is a single-entry output register that can be refilled in the same cycle it drains; full throughput is 1 word/cycle.
- Grant in Mode 0:
  - Grant channel Select when Select < N and InValid[Select]=1.
  - Select >= N, or InValid[Select]=0, means no grant.
- Grant in Mode 1: grant the first channel with InValid=1, searching Ptr+1, Ptr+2, ... modulo N and wrapping past N-1 to 0.
- Handshake:
  - InReady[g] = LoadEn for the granted channel g only; all other InReady bits are 0.
  - InReady never depends on InValid of a non-granted channel; it depends only on the grant logic.
- Transfer: when the grant is valid and LoadEn=1, at the next edge:
  - OutData = InData[g].
  - OutChan = g.
  - OutValid = 1.
  - In Mode 1 only, Ptr = g. Ptr is unchanged in Mode 0.
- Drain: OutValid=1, OutReady=1 and no grant gives OutValid=0 at the next edge. OutData and OutChan keep their last values.
- Hold: OutValid=1 and OutReady=0 leaves OutData, OutChan and OutValid stable, and all InReady=0.
- Latency: input accepted at edge k appears on OutData after edge k, i.e. 1 cycle.
- Mode or Select changes:
  - Sampled combinationally each cycle.
  - Never affect a word already held in the output register.
- Fairness: in Mode 1, with all N inputs continuously valid and OutReady=1, grants cycle 0,1,...,N-1,0. No channel waits more than N-1 transfers.

Decomposition:
- Shared package `mux_pkg`:
  - Constant MODE_FIXED=1'b0, MODE_RR=1'b1.
  - Helper function for the SW computation.
- One natural sub-module, `rr_arbiter`: N-bit request and SW-bit pointer in, one-hot grant plus encoded index plus any-grant out. It is purely combinational; Ptr stays in the parent.
- The parent holds the output register, the pointer, LoadEn and the Mode 0 path.

Test Plan:
1. Reset and Mode 0 transfer:
   - Stimulus: RST_N=0 for 2 cycles, then Mode=0, Select=2, InValid=4'b0100, InData ch2=8'hA5, OutReady=1.
   - Required: InReady=4'b0100 in that cycle; next cycle OutValid=1, OutData=8'hA5, OutChan=2.
2. Backpressure:
   - Stimulus: hold OutReady=0 for 3 cycles with ch1 valid (8'h3C).
   - Required: OutData stays at the first word; InReady=0 throughout. After OutReady=1, 8'h3C loads the next cycle.
3. Round-robin fairness:
   - Stimulus: Mode=1, InValid=4'b1111, OutReady=1 for 8 cycles.
   - Required: OutChan sequence 0,1,2,3,0,1,2,3.
4. Sparse round-robin with wrap:
   - Stimulus: InValid=4'b1001, Ptr=0 after a grant on ch0.
   - Required: next grant is ch3, then ch0.
5. Invalid Select and empty inputs:
   - Stimulus: N=3, Mode=0, Select=3, all inputs valid; then Mode=1 with InValid=0.
   - Required: InReady=0 in both cases; OutValid drops after draining.
6. Reset mid-operation:
   - Stimulus: assert RST_N=0 while OutValid=1 and OutReady=0.
   - Required: next edge OutValid=0, OutData=0. After release, the first Mode 1 grant goes to the lowest valid channel.
